dcache_wb_buffer: RTL and testbench
===================================

DCACHE_WB_BUFFER -- requirements
Module: dcache_wb_buffer

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 256, cache line width in bits.
REQ-002 SHALL have parameter BEAT_WIDTH, default 64, memory burst beat width in bits.
REQ-003 SHALL have parameter BURST_BEATS, default 4, beats per line (LINE_WIDTH/BEAT_WIDTH).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port evict_valid  input  1  dirty-line eviction request.
REQ-007 SHALL have port evict_ready  output  1  buffer empty and able to accept.
REQ-008 SHALL have port evict_addr  input  32  address of the evicted line, any byte offset.
REQ-009 SHALL have port evict_data  input  LINE_WIDTH  line read from the data array, valid with evict_valid.
REQ-010 SHALL have port bmem_addr  output  32  line-aligned write-back address.
REQ-011 SHALL have port bmem_write  output  1  burst write request.
REQ-012 SHALL have port bmem_wdata  output  BEAT_WIDTH  current beat data.
REQ-013 SHALL have port bmem_ready  input  1  memory accepts the current beat.
REQ-014 SHALL have port wb_done  output  1  single-cycle pulse after the final beat is accepted.
REQ-015 SHALL have port lookup_addr  input  32  refill-path probe address.
REQ-016 SHALL have port lookup_hit  output  1  probe matches the held line.
REQ-017 SHALL have port lookup_data  output  LINE_WIDTH  held line, for forwarding.

Function
REQ-018 SHALL implement states IDLE, BURST, DONE.
REQ-019 SHALL drive evict_ready=1 only in IDLE.
REQ-020 SHALL, in IDLE with evict_valid=1, capture evict_data and {evict_addr[31:5],5'b0}, clear beat counter, and enter BURST next cycle.
REQ-021 SHALL, in BURST, hold bmem_write=1 and bmem_addr constant for all beats.
REQ-022 SHALL drive bmem_wdata = held line bits [BEAT_WIDTH*k +: BEAT_WIDTH] for beat k, starting at k=0.
REQ-023 SHALL advance k only on a cycle with bmem_ready=1; with bmem_ready=0, outputs are held unchanged indefinitely.
REQ-024 SHALL, on acceptance of beat BURST_BEATS-1, enter DONE; beat counter SHALL NOT wrap into a fifth beat.
REQ-025 SHALL, in DONE, drive bmem_write=0 and wb_done=1 for exactly one cycle, then return to IDLE.
REQ-026 SHALL ignore evict_valid in BURST and DONE; the held line SHALL NOT be overwritten.
REQ-027 SHALL assert lookup_hit combinationally when state is BURST or DONE and lookup_addr[31:5] equals the held line address bits [31:5].
REQ-028 SHALL drive lookup_data = held line while lookup_hit=1, else all zeros.
REQ-029 SHALL NOT hit on a line being captured in the same IDLE cycle; hit begins the first BURST cycle.
REQ-030 SHALL ignore bmem_ready outside BURST.
REQ-031 SHALL have minimum occupancy of 1 capture + BURST_BEATS beats + 1 DONE cycle; back-to-back evictions SHALL be accepted no sooner than the cycle after DONE.

Reset
REQ-032 SHALL, with rst=1 at a clock edge, enter IDLE, clear beat counter, and invalidate the held line.
REQ-033 SHALL drive after reset: evict_ready=1, bmem_write=0, bmem_addr=0, bmem_wdata=0, wb_done=0, lookup_hit=0, lookup_data=0.
REQ-034 SHALL, on reset mid-burst, abandon the burst with no wb_done pulse; bmem_write SHALL be 0 the following cycle.

Configuration
REQ-035 SHALL compile lookup forwarding (REQ-027..REQ-029) only when DCACHE_WB_FWD_EN is defined.
REQ-036 SHALL, without DCACHE_WB_FWD_EN, tie lookup_hit=0 and lookup_data=0 and keep ports present; write-back behaviour is otherwise identical.

Structure
REQ-037 SHALL take LINE_WIDTH, BEAT_WIDTH, BURST_BEATS defaults and the wb_state_t enum (IDLE, BURST, DONE) from shared package dcache_pkg.
REQ-038 SHALL be a single module with no sub-modules; beat selection is an indexed part-select.

Verification
REQ-039 SHALL cover: evict addr 0x0000_1234, data 256'h{0x44..,0x33..,0x22..,0x11..}, bmem_ready=1 -> bmem_addr 0x0000_1220, wdata 0x11..,0x22..,0x33..,0x44.. on 4 consecutive cycles, wb_done one cycle later.
REQ-040 SHALL cover: bmem_ready low 3 cycles before beat 2 -> beat 2 data and bmem_addr stable across the stall, total 4 accepted beats.
REQ-041 SHALL cover: second evict_valid during BURST -> ignored, evict_ready=0, first line's data emitted unchanged.
REQ-042 SHALL cover: lookup_addr 0x0000_123C during BURST of line 0x1220 -> lookup_hit=1, lookup_data=held line; 0x0000_1240 -> hit=0, data=0 (with DCACHE_WB_FWD_EN).
REQ-043 SHALL cover: rst asserted after beat 1 -> next cycle bmem_write=0, evict_ready=1, no wb_done.
REQ-044 SHALL cover: build without DCACHE_WB_FWD_EN, matching lookup -> lookup_hit=0 throughout.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared configuration and state encoding for the data-cache write-back path.
package dcache_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BEAT_WIDTH  = 64;
    localparam int BURST_BEATS = LINE_WIDTH / BEAT_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/dcache_wb_buffer.sv
// Single-entry dirty-line write-back buffer: captures one evicted line and bursts it to memory.
// Define DCACHE_WB_FWD_EN to compile refill-path lookup forwarding of the held line.
module dcache_wb_buffer
    import dcache_pkg::*;
#(
    parameter int LINE_WIDTH  = dcache_pkg::LINE_WIDTH,
    parameter int BEAT_WIDTH  = dcache_pkg::BEAT_WIDTH,
    parameter int BURST_BEATS = dcache_pkg::BURST_BEATS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  evict_valid,
    output logic                  evict_ready,
    input  logic [31:0]           evict_addr,
    input  logic [LINE_WIDTH-1:0] evict_data,
    output logic [31:0]           bmem_addr,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    output logic                  wb_done,
    input  logic [31:0]           lookup_addr,
    output logic                  lookup_hit,
    output logic [LINE_WIDTH-1:0] lookup_data
);

    localparam int CNT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

    wb_state_t             state;
    logic [CNT_W-1:0]      beat;
    logic [LINE_WIDTH-1:0] held_line;
    logic [26:0]           held_tag;

    // Line payload is never reset; it is only observable while state != IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (evict_valid) begin
                        held_line <= evict_data;
                        held_tag  <= evict_addr[31:5];
                        beat      <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (bmem_ready) begin
                        if (beat == LAST_BEAT) begin
                            state <= DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign evict_ready = (state == IDLE);
    assign bmem_write  = (state == BURST);
    assign wb_done     = (state == DONE);
    assign bmem_addr   = bmem_write ? {held_tag, 5'b0} : 32'd0;
    assign bmem_wdata  = bmem_write ? held_line[int'(beat)*BEAT_WIDTH +: BEAT_WIDTH] : '0;

`ifdef DCACHE_WB_FWD_EN
    // The line is only forwardable once it has left IDLE, so a same-cycle capture never hits.
    logic line_held;
    assign line_held   = (state != IDLE);
    assign lookup_hit  = line_held && (lookup_addr[31:5] == held_tag);
    assign lookup_data = lookup_hit ? held_line : '0;

    logic unused_bits;
    assign unused_bits = &{1'b0, evict_addr[4:0], lookup_addr[4:0]};
`else
    assign lookup_hit  = 1'b0;
    assign lookup_data = '0;

    logic unused_bits;
    assign unused_bits = &{1'b0, evict_addr[4:0], lookup_addr};
`endif

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer with a queue-based transaction model checked every cycle.
module tb_dcache_wb_buffer;

`ifdef DCACHE_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         evict_valid;
    logic         evict_ready;
    logic [31:0]  evict_addr;
    logic [255:0] evict_data;
    logic [31:0]  bmem_addr;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic         wb_done;
    logic [31:0]  lookup_addr;
    logic         lookup_hit;
    logic [255:0] lookup_data;

    always #5 clk = ~clk;

    dcache_wb_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .evict_valid (evict_valid),
        .evict_ready (evict_ready),
        .evict_addr  (evict_addr),
        .evict_data  (evict_data),
        .bmem_addr   (bmem_addr),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .wb_done     (wb_done),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction model: a line is a queue of pending beats, then one done cycle.
    logic [63:0]  m_q[$];
    bit           m_done = 1'b0;
    logic [31:0]  m_addr = '0;
    logic [255:0] m_line = '0;

    always @(negedge clk) begin
        logic busy;
        logic hit;
        busy = (m_q.size() > 0);
        hit  = FWD && (busy || m_done) && (lookup_addr[31:5] == m_addr[31:5]);
        if (chk_en) begin
            check("evict_ready", evict_ready, !busy && !m_done);
            check("bmem_write",  bmem_write,  busy);
            check("bmem_addr",   bmem_addr,   busy ? m_addr : 32'd0);
            check("bmem_wdata",  bmem_wdata,  busy ? m_q[0] : 64'd0);
            check("wb_done",     wb_done,     m_done);
            check("lookup_hit",  lookup_hit,  hit);
            check("lookup_data", lookup_data, hit ? m_line : 256'd0);
        end
        // Inputs are stable here and are what the next rising edge samples.
        if (rst) begin
            m_q.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (busy) begin
            if (bmem_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (evict_valid) begin
            m_addr = {evict_addr[31:5], 5'b0};
            m_line = evict_data;
            for (int k = 0; k < 4; k++) m_q.push_back(evict_data[64*k +: 64]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    localparam logic [255:0] D1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] D2 = {64'hDEAD_BEEF_0000_0003, 64'hCAFE_F00D_0000_0002,
                                   64'h0123_4567_89AB_0001, 64'hFEDC_BA98_7654_0000};

    initial begin
        rst = 1'b1; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
        bmem_ready = 1'b0; lookup_addr = '0;
        cyc(); cyc();
        rst = 1'b0; chk_en = 1'b1;
        check("rst_evict_ready", evict_ready, 1'b1);
        check("rst_bmem_write",  bmem_write,  1'b0);
        check("rst_bmem_addr",   bmem_addr,   32'd0);
        check("rst_lookup_data", lookup_data, 256'd0);

        // Basic eviction with memory always ready
        evict_valid = 1'b1; evict_addr = 32'h0000_1234; evict_data = D1; bmem_ready = 1'b1;
        lookup_addr = 32'h0000_1234;
        check("capture_no_hit", lookup_hit, 1'b0);
        cyc();
        evict_valid = 1'b0; lookup_addr = 32'h0000_123C;
        check("t1_addr",   bmem_addr,  32'h0000_1220);
        check("t1_beat0",  bmem_wdata, 64'h1111_1111_1111_1111);
        check("t1_hit",    lookup_hit, FWD);
        check("t1_ldata",  lookup_data, FWD ? D1 : 256'd0);
        cyc();
        lookup_addr = 32'h0000_1240;
        check("t1_beat1",  bmem_wdata, 64'h2222_2222_2222_2222);
        check("t1_miss",   lookup_hit, 1'b0);
        cyc();
        check("t1_beat2",  bmem_wdata, 64'h3333_3333_3333_3333);
        cyc();
        check("t1_beat3",  bmem_wdata, 64'h4444_4444_4444_4444);
        check("t1_addr3",  bmem_addr,  32'h0000_1220);
        cyc();
        check("t1_done",   wb_done,    1'b1);
        check("t1_nowr",   bmem_write, 1'b0);
        cyc();
        check("t1_idle_done", wb_done, 1'b0);
        check("t1_idle_rdy",  evict_ready, 1'b1);

        // Stall before beat 2
        evict_valid = 1'b1; evict_addr = 32'h8000_0047; evict_data = D2;
        cyc();
        evict_valid = 1'b0;
        cyc();
        cyc();
        bmem_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cyc();
            check("t2_stall_data", bmem_wdata, 64'hCAFE_F00D_0000_0002);
            check("t2_stall_addr", bmem_addr,  32'h8000_0040);
        end
        bmem_ready = 1'b1;
        cyc();
        check("t2_beat3", bmem_wdata, 64'hDEAD_BEEF_0000_0003);
        cyc();
        check("t2_done", wb_done, 1'b1);
        cyc();

        // Second eviction during a burst is ignored
        evict_valid = 1'b1; evict_addr = 32'h0000_1000; evict_data = D1;
        cyc();
        evict_addr = 32'h0000_2000; evict_data = D2;
        check("t3_not_ready", evict_ready, 1'b0);
        check("t3_beat0", bmem_wdata, 64'h1111_1111_1111_1111);
        for (int k = 1; k < 4; k++) begin
            cyc();
            check("t3_beat", bmem_wdata, D1[64*k +: 64]);
            check("t3_addr", bmem_addr,  32'h0000_1000);
        end
        cyc();
        evict_valid = 1'b0;
        check("t3_done", wb_done, 1'b1);
        cyc();

        // Reset in the middle of a burst
        evict_valid = 1'b1; evict_addr = 32'h0000_3000; evict_data = D2;
        cyc();
        evict_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t4_nowr",  bmem_write,  1'b0);
        check("t4_ready", evict_ready, 1'b1);
        check("t4_nodone", wb_done,    1'b0);
        cyc();
        check("t4_nodone2", wb_done,   1'b0);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
